exe_mem_stage: RTL and testbench

Pipeline stage directly downstream of the ALU: captures the ALU result, flags and forwarded control/store data each accepted cycle, presents them to the memory stage through a valid/ready handshake with a two-entry skid buffer, and owns the architectural NZCV status register. The status register feeds the carry back to the ALU (inC) and the condition checker in decode.

---
 rtl/exe_mem_stage.sv | 133 +++++++++++++
 tb/tb_exe_mem_stage.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/exe_mem_stage.sv
// exe_mem_stage: EX->MEM pipeline register with a two-entry skid buffer.
// Also holds the architectural NZCV status register fed back to the ALU.
module exe_mem_stage #(
   parameter int DATA_W     = 32,
   parameter int REG_ADDR_W = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  valid_in,
   output logic                  ready_out,
   input  logic [DATA_W-1:0]     alu_result,
   input  logic                  alu_n,
   input  logic                  alu_z,
   input  logic                  alu_c,
   input  logic                  alu_v,
   input  logic                  s_in,
   input  logic                  wb_en_in,
   input  logic                  mem_r_en_in,
   input  logic                  mem_w_en_in,
   input  logic [REG_ADDR_W-1:0] dest_in,
   input  logic [DATA_W-1:0]     val_rm_in,
   output logic                  valid_out,
   input  logic                  ready_in,
   output logic [DATA_W-1:0]     alu_res_out,
   output logic [DATA_W-1:0]     val_rm_out,
   output logic [REG_ADDR_W-1:0] dest_out,
   output logic                  wb_en_out,
   output logic                  mem_r_en_out,
   output logic                  mem_w_en_out,
   output logic [3:0]            status
);

   typedef struct packed {
      logic [DATA_W-1:0]     res;
      logic [DATA_W-1:0]     rm;
      logic [REG_ADDR_W-1:0] dest;
      logic                  wb;
      logic                  mr;
      logic                  mw;
   } entry_t;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_t;

   state_t     state_q;
   entry_t     main_q;
   entry_t     skid_q;
   entry_t     in_e;
   logic [3:0] status_q;
   logic [3:0] status_d;
   logic       accept;

   assign in_e = '{
      res:  alu_result,
      rm:   val_rm_in,
      dest: dest_in,
      wb:   wb_en_in,
      mr:   mem_r_en_in,
      mw:   mem_w_en_in
   };

   // Both handshake outputs come straight from the state register.
   assign ready_out = (state_q != TWO);
   assign valid_out = (state_q != EMPTY);
   assign accept    = valid_in & ready_out;

   // Buffer occupancy FSM; flush keeps main data so outputs hold when empty.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= EMPTY;
         main_q  <= '0;
         skid_q  <= '0;
      end else if (flush) begin
         state_q <= EMPTY;
      end else begin
         unique case (state_q)
            EMPTY: begin
               if (valid_in) begin
                  main_q  <= in_e;
                  state_q <= ONE;
               end
            end
            ONE: begin
               if (valid_in && ready_in) begin
                  main_q <= in_e;
               end else if (valid_in) begin
                  skid_q  <= in_e;
                  state_q <= TWO;
               end else if (ready_in) begin
                  state_q <= EMPTY;
               end
            end
            TWO: begin
               if (ready_in) begin
                  main_q  <= skid_q;
                  state_q <= ONE;
               end
            end
            default: state_q <= EMPTY;
         endcase
      end
   end

   // Flags commit at accept so the next ALU op sees them despite stalls.
   always_comb begin
      status_d = status_q;
      if (accept && s_in && !flush) begin
         status_d = {alu_n, alu_z, alu_c, alu_v};
      end
   end

   // Status register; only reset clears it, flush leaves it alone.
   always_ff @(posedge clk) begin
      if (rst) begin
         status_q <= 4'b0000;
      end else begin
         status_q <= status_d;
      end
   end

   assign alu_res_out  = main_q.res;
   assign val_rm_out   = main_q.rm;
   assign dest_out     = main_q.dest;
   assign wb_en_out    = main_q.wb & valid_out;
   assign mem_r_en_out = main_q.mr & valid_out;
   assign mem_w_en_out = main_q.mw & valid_out;
   assign status       = status_q;

endmodule

// File: tb/tb_exe_mem_stage.sv
// tb_exe_mem_stage: directed and random stimulus against a queue model.
// The model treats the stage as a 2-deep FIFO plus a flag register.
module tb_exe_mem_stage;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, flush, valid_in, ready_in, s_in;
   logic        alu_n, alu_z, alu_c, alu_v;
   logic        wb_en_in, mem_r_en_in, mem_w_en_in;
   logic [31:0] alu_result, val_rm_in;
   logic [3:0]  dest_in;
   logic        ready_out, valid_out;
   logic [31:0] alu_res_out, val_rm_out;
   logic [3:0]  dest_out;
   logic        wb_en_out, mem_r_en_out, mem_w_en_out;
   logic [3:0]  status;

   exe_mem_stage #(.DATA_W(32), .REG_ADDR_W(4)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .valid_in(valid_in), .ready_out(ready_out),
      .alu_result(alu_result),
      .alu_n(alu_n), .alu_z(alu_z), .alu_c(alu_c), .alu_v(alu_v),
      .s_in(s_in), .wb_en_in(wb_en_in),
      .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
      .dest_in(dest_in), .val_rm_in(val_rm_in),
      .valid_out(valid_out), .ready_in(ready_in),
      .alu_res_out(alu_res_out), .val_rm_out(val_rm_out),
      .dest_out(dest_out), .wb_en_out(wb_en_out),
      .mem_r_en_out(mem_r_en_out), .mem_w_en_out(mem_w_en_out),
      .status(status)
   );

   int checks   = 0;
   int failures = 0;

   task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   typedef struct {
      logic [31:0] res;
      logic [31:0] rm;
      logic [3:0]  dest;
      logic        wb, mr, mw;
   } ent_t;

   ent_t       q[$];
   ent_t       last;
   logic [3:0] st_m;

   // What the stage holds after one clock edge with the current inputs.
   task automatic model_edge();
      ent_t e;
      bit   acc, hand;
      e = '{alu_result, val_rm_in, dest_in, wb_en_in, mem_r_en_in, mem_w_en_in};
      if (rst) begin
         q.delete();
         last = '{32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0};
         st_m = 4'h0;
      end else if (flush) begin
         q.delete();
      end else begin
         acc  = valid_in && (q.size() < 2);
         hand = (q.size() > 0) && ready_in;
         if (hand) void'(q.pop_front());
         if (acc) begin
            q.push_back(e);
            if (s_in) st_m = {alu_n, alu_z, alu_c, alu_v};
         end
      end
      if (q.size() > 0) last = q[0];
   endtask

   task automatic check_all(string tag);
      bit ne;
      ne = (q.size() > 0);
      check_eq({tag, ".valid"}, 32'(valid_out), 32'(ne));
      check_eq({tag, ".ready"}, 32'(ready_out), 32'(q.size() < 2));
      check_eq({tag, ".res"}, alu_res_out, last.res);
      check_eq({tag, ".rm"}, val_rm_out, last.rm);
      check_eq({tag, ".dest"}, 32'(dest_out), 32'(last.dest));
      check_eq({tag, ".wb"}, 32'(wb_en_out), 32'(ne & last.wb));
      check_eq({tag, ".mr"}, 32'(mem_r_en_out), 32'(ne & last.mr));
      check_eq({tag, ".mw"}, 32'(mem_w_en_out), 32'(ne & last.mw));
      check_eq({tag, ".status"}, 32'(status), 32'(st_m));
   endtask

   task automatic cyc(string tag);
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_all(tag);
   endtask

   task automatic drv(bit v, logic [31:0] r, bit rdy,
                      bit s, logic [3:0] f, logic [2:0] ctl);
      valid_in    = v;
      alu_result  = r;
      val_rm_in   = r ^ 32'h5a5a_0000;
      dest_in     = r[3:0];
      ready_in    = rdy;
      s_in        = s;
      {alu_n, alu_z, alu_c, alu_v} = f;
      {wb_en_in, mem_r_en_in, mem_w_en_in} = ctl;
   endtask

   initial begin
      logic [3:0] saved;
      rst   = 1'b1;
      flush = 1'b0;
      drv(1, 32'h77, 1, 1, 4'hF, 3'b111);
      last = '{32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0};
      st_m = 4'h0;

      // reset with valid_in high
      cyc("rst0");
      cyc("rst1");
      check_eq("rst.status", 32'(status), 32'h0);
      check_eq("rst.ready", 32'(ready_out), 32'h1);
      check_eq("rst.valid", 32'(valid_out), 32'h0);
      rst = 1'b0;

      // streaming
      drv(1, 32'h1, 1, 0, 4'h0, 3'b100); cyc("str1");
      check_eq("stream.1", alu_res_out, 32'h1);
      drv(1, 32'h2, 1, 0, 4'h0, 3'b100); cyc("str2");
      check_eq("stream.2", alu_res_out, 32'h2);
      drv(1, 32'h3, 1, 0, 4'h0, 3'b100); cyc("str3");
      check_eq("stream.3", alu_res_out, 32'h3);
      drv(0, 32'h0, 1, 0, 4'h0, 3'b000); cyc("str4");
      check_eq("stream.drain", 32'(valid_out), 32'h0);

      // back-pressure: A shown, then ready_in low two cycles
      drv(1, 32'hA, 1, 0, 4'h0, 3'b100); cyc("bp1");
      drv(1, 32'hB, 0, 0, 4'h0, 3'b100); cyc("bp2");
      check_eq("bp.ready_low", 32'(ready_out), 32'h0);
      check_eq("bp.holdA", alu_res_out, 32'hA);
      drv(1, 32'hC, 0, 0, 4'h0, 3'b100); cyc("bp3");
      drv(1, 32'hC, 1, 0, 4'h0, 3'b100); cyc("bp4");
      check_eq("bp.showB", alu_res_out, 32'hB);
      drv(1, 32'hC, 1, 0, 4'h0, 3'b100); cyc("bp5");
      check_eq("bp.showC", alu_res_out, 32'hC);
      drv(0, 32'h0, 1, 0, 4'h0, 3'b000); cyc("bp6");
      check_eq("bp.empty", 32'(valid_out), 32'h0);

      // status: SUBS result 0 then ADD without S
      drv(1, 32'h0, 1, 1, 4'b0110, 3'b100); cyc("st1");
      check_eq("st.subs", 32'(status), 32'h6);
      drv(1, 32'h5, 1, 0, 4'b1001, 3'b100); cyc("st2");
      check_eq("st.add_nos", 32'(status), 32'h6);
      drv(0, 32'h0, 1, 0, 4'h0, 3'b000); cyc("st3");
      drv(1, 32'h9, 0, 1, 4'b1010, 3'b100); cyc("st4");
      check_eq("st.stalled", 32'(status), 32'hA);

      // flush while full
      drv(1, 32'h10, 0, 0, 4'h0, 3'b100); cyc("fl1");
      check_eq("fl.full", 32'(ready_out), 32'h0);
      saved = status;
      flush = 1'b1;
      drv(1, 32'h11, 0, 1, 4'hF, 3'b111); cyc("fl2");
      flush = 1'b0;
      check_eq("fl.valid", 32'(valid_out), 32'h0);
      check_eq("fl.ready", 32'(ready_out), 32'h1);
      check_eq("fl.status", 32'(status), 32'(saved));

      // store handed off then idle
      drv(1, 32'h400, 1, 0, 4'h0, 3'b001); cyc("sw1");
      check_eq("sw.mw_on", 32'(mem_w_en_out), 32'h1);
      drv(0, 32'h0, 1, 0, 4'h0, 3'b000); cyc("sw2");
      check_eq("sw.mw_off", 32'(mem_w_en_out), 32'h0);
      check_eq("sw.addr", alu_res_out, 32'h400);

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         rst   = ($urandom_range(0, 99) == 0);
         flush = ($urandom_range(0, 19) == 0);
         drv($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) != 0,
             $urandom_range(0, 1) == 1, 4'($urandom), 3'($urandom));
         cyc("rnd");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
